// File: rtl/dsdemod2_if.sv
// Bitstream-in / PCM-out bundle between a delta-sigma source and the dsdemod2 decimator.
// The master drives the bitstream and accept enable; the slave returns strobed PCM words.
interface dsdemod2_if #(
    parameter int n = 4
) ();
    logic                in;
    logic                en;
    logic signed [n-1:0] out;
    logic                valid;

    modport master (output in, output en, input out, input valid);
    modport slave  (input in, input en, output out, output valid);
endinterface

// File: rtl/dsdemod2.sv
// Second-order CIC (sinc^2) decimator recovering signed n-bit PCM from a 1-bit
// delta-sigma stream; emits one strobed word per 2^k accepted bits.
module dsdemod2 #(
    parameter int n = 4,
    parameter int k = 4
) (
    input  logic         clk,
    input  logic         clr,
    dsdemod2_if.slave    bus
);
    localparam int W  = 2 * k + 2;
    localparam int R  = 2 ** k;
    localparam int SH = 2 * k - (n - 1);

    localparam logic signed [W-1:0] ONE     = W'(1);
    localparam logic signed [W-1:0] NEG_ONE = '1;
    localparam logic signed [W-1:0] MAX_W   = W'(2 ** (n - 1) - 1);
    localparam logic signed [W-1:0] MIN_W   = W'(-(2 ** (n - 1)));
    localparam logic [k-1:0]        CNT_TOP = k'(R - 1);

    logic signed [W-1:0] i1_q, i1_d;
    logic signed [W-1:0] i2_q, i2_d;
    logic signed [W-1:0] d1_q, d1_d;
    logic signed [W-1:0] d2_q, d2_d;
    logic [k-1:0]        cnt_q, cnt_d;
    logic signed [n-1:0] out_q, out_d;
    logic                valid_q, valid_d;

    logic signed [W-1:0] x;
    logic signed [W-1:0] c1;
    logic signed [W-1:0] c2;
    logic signed [W-1:0] c2_sh;

    // Only the positive full-scale value can overflow after the shift, but clamp
    // both ends so warm-up transients never wrap into the wrong sign.
    function automatic logic signed [n-1:0] sat(input logic signed [W-1:0] v);
        if (v > MAX_W) begin
            return MAX_W[n-1:0];
        end else if (v < MIN_W) begin
            return MIN_W[n-1:0];
        end else begin
            return v[n-1:0];
        end
    endfunction

    always_comb begin
        x       = bus.in ? ONE : NEG_ONE;
        i1_d    = i1_q;
        i2_d    = i2_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        valid_d = 1'b0;
        c1      = '0;
        c2      = '0;
        c2_sh   = '0;
        if (bus.en) begin
            // Integrators wrap modulo 2^W; the comb differences stay exact regardless.
            i1_d  = i1_q + x;
            i2_d  = i2_q + i1_q;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_TOP) begin
                c1      = i2_q - d1_q;
                c2      = c1 - d2_q;
                c2_sh   = c2 >>> SH;
                d1_d    = i2_q;
                d2_d    = c1;
                out_d   = sat(c2_sh);
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            i1_q    <= '0;
            i2_q    <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            i1_q    <= i1_d;
            i2_q    <= i2_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign bus.out   = out_q;
    assign bus.valid = valid_q;
endmodule
